// File: rtl/l1_dcache_ctrl_pkg.sv
// Shared CPU defines for the L1 data cache.
// Holds the address-field widths, the default tag-entry layout
// {valid, dirty, tag[21:0]}, the cache controller FSM encoding and the
// common CPU masks (DM_UNIT_MASK, REG_LEN, L1_INDEX_MASK).
package l1_dcache_ctrl_pkg;

  localparam int REG_LEN       = 32;
  localparam int OFFSET_BITS   = 5;
  localparam int L1_INDEX_BITS = 5;
  localparam int TAG_BITS      = REG_LEN - L1_INDEX_BITS - OFFSET_BITS;
  localparam int TAG_ENTRY_W   = TAG_BITS + 2;

  // Line-aligned address of a data-memory unit (one cache line).
  localparam logic [REG_LEN-1:0] DM_UNIT_MASK  = 32'hFFFF_FFE0;
  // Set-index field inside a byte address.
  localparam logic [REG_LEN-1:0] L1_INDEX_MASK = 32'h0000_03E0;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } tag_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2,
    ST_REFILL    = 2'd3
  } dc_state_t;

endpackage

// File: rtl/l1_dcache_ctrl_sram.sv
// Tag and data storage for the direct-mapped L1 data cache.
// One asynchronous read port (rd_index -> rd_entry, rd_line) and one
// synchronous write port that updates tag entry and line together.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears valid/dirty)
//   rd_index            set being looked up
//   rd_entry, rd_line   {valid, dirty, tag} entry and line of that set
//   wr_en, wr_index     write strobe and target set
//   wr_entry, wr_line   new entry and line
module dcache_sram
  import l1_dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int LINE_BITS  = 256,
  parameter int ENTRY_W    = TAG_ENTRY_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic [ENTRY_W-1:0]    rd_entry,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [ENTRY_W-1:0]    wr_entry,
  input  logic [LINE_BITS-1:0]  wr_line
);

  localparam int SETS = 1 << INDEX_BITS;

  logic [ENTRY_W-1:0]   tag_memory  [SETS];
  logic [LINE_BITS-1:0] data_memory [SETS];

  assign rd_entry = tag_memory[rd_index];
  assign rd_line  = data_memory[rd_index];

  // Only the valid/dirty flags are reset; stale tags are harmless once invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SETS; i++) begin
        tag_memory[i][ENTRY_W-1 -: 2] <= 2'b00;
      end
    end else if (wr_en) begin
      tag_memory[wr_index] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_memory[wr_index] <= wr_line;
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served combinationally; misses stall the CPU while the FSM
// writes back a dirty victim, fetches the new line and spends one refill
// cycle before the held request is re-evaluated as a hit.
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   cpu_addr_i/data_i     request address and store data
//   cpu_read_i/write_i    load / store request (mutually exclusive)
//   cpu_data_o            load data
//   cpu_stall_o           pipeline freeze
//   mem_data_i, mem_ack_i refill line and one-cycle completion pulse
//   mem_data_o/addr_o     write-back line and line-aligned address
//   mem_enable_o/write_o  memory request valid, 1 = write-back
module l1_dcache_ctrl
  import l1_dcache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 5,
  parameter int LINE_BITS  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [REG_LEN-1:0]   cpu_addr_i,
  input  logic [REG_LEN-1:0]   cpu_data_i,
  input  logic                 cpu_read_i,
  input  logic                 cpu_write_i,
  output logic [REG_LEN-1:0]   cpu_data_o,
  output logic                 cpu_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [REG_LEN-1:0]   mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
);

  localparam int OFF_W   = $clog2(LINE_BITS / 8);
  localparam int TAG_W   = REG_LEN - INDEX_BITS - OFF_W;
  localparam int ENTRY_W = TAG_W + 2;
  localparam int WORDS   = LINE_BITS / REG_LEN;
  localparam int WSEL_W  = $clog2(WORDS);

  dc_state_t state;

  logic                 mem_enable_q;
  logic                 mem_write_q;
  logic [REG_LEN-1:0]   mem_addr_q;
  logic [LINE_BITS-1:0] mem_data_q;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [WSEL_W-1:0]     req_word;
  logic                  req_active;
  logic                  unused_addr_bits;

  logic [ENTRY_W-1:0]   rd_entry;
  logic [LINE_BITS-1:0] rd_line;
  logic                 ent_valid;
  logic                 ent_dirty;
  logic [TAG_W-1:0]     ent_tag;
  logic                 hit;
  logic                 miss;

  logic [WORDS-1:0][REG_LEN-1:0] line_words;
  logic [WORDS-1:0][REG_LEN-1:0] merged_words;

  logic                 wr_en;
  logic [ENTRY_W-1:0]   wr_entry;
  logic [LINE_BITS-1:0] wr_line;

  assign req_tag          = cpu_addr_i[REG_LEN-1 -: TAG_W];
  assign req_index        = cpu_addr_i[OFF_W +: INDEX_BITS];
  assign req_word         = cpu_addr_i[2 +: WSEL_W];
  assign req_active       = cpu_read_i | cpu_write_i;
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_sram #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_BITS  (LINE_BITS),
    .ENTRY_W    (ENTRY_W)
  ) dcache_sram (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rd_index (req_index),
    .rd_entry (rd_entry),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (req_index),
    .wr_entry (wr_entry),
    .wr_line  (wr_line)
  );

  assign ent_valid  = rd_entry[ENTRY_W-1];
  assign ent_dirty  = rd_entry[ENTRY_W-2];
  assign ent_tag    = rd_entry[TAG_W-1:0];
  assign hit        = req_active & ent_valid & (ent_tag == req_tag);
  assign miss       = req_active & ~hit;
  assign line_words = rd_line;

  // Only a miss seen in IDLE stalls from IDLE; every other state stalls
  // unconditionally, including REFILL where the tag already matches.
  assign cpu_stall_o  = rst_i & ((state == ST_IDLE) ? miss : 1'b1);
  assign cpu_data_o   = rst_i ? line_words[req_word] : '0;
  assign mem_enable_o = rst_i & mem_enable_q;
  assign mem_write_o  = rst_i & mem_write_q;
  assign mem_addr_o   = rst_i ? mem_addr_q : '0;
  assign mem_data_o   = rst_i ? mem_data_q : '0;

  // Write port: store hit merges one word and marks dirty; the refill ack
  // installs the fetched line clean. Nothing is written while in reset.
  always_comb begin
    merged_words           = line_words;
    merged_words[req_word] = cpu_data_i;
    wr_en                  = 1'b0;
    wr_entry               = '0;
    wr_line                = rd_line;
    if (rst_i) begin
      if (state == ST_IDLE && hit && cpu_write_i) begin
        wr_en    = 1'b1;
        wr_entry = {1'b1, 1'b1, req_tag};
        wr_line  = merged_words;
      end else if (state == ST_ALLOCATE && mem_ack_i) begin
        wr_en    = 1'b1;
        wr_entry = {1'b1, 1'b0, req_tag};
        wr_line  = mem_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            mem_enable_q <= 1'b1;
            if (ent_valid && ent_dirty) begin
              state       <= ST_WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {ent_tag, req_index, {OFF_W{1'b0}}};
            end else begin
              state       <= ST_ALLOCATE;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, req_index, {OFF_W{1'b0}}};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            state       <= ST_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_tag, req_index, {OFF_W{1'b0}}};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            state        <= ST_REFILL;
            mem_enable_q <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Victim line captured when the miss is accepted; held through write-back.
  always_ff @(posedge clk_i) begin
    if (state == ST_IDLE && miss && ent_valid && ent_dirty) begin
      mem_data_q <= rd_line;
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
module tb_l1_dcache_ctrl;
  import l1_dcache_ctrl_pkg::*;

  logic         clk;
  logic         rst_i;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [255:0] mem_rdata;
  logic         ack_auto;
  logic         ack_man;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  l1_dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_i   (cpu_wdata),
    .cpu_read_i   (cpu_read),
    .cpu_write_i  (cpu_write),
    .cpu_data_o   (cpu_data_o),
    .cpu_stall_o  (cpu_stall_o),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (ack_auto | ack_man),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t        log_q[$];
  int          lat = 10;
  logic        auto_on = 1'b1;
  logic [31:0] fill_word = 32'h0;
  logic        seen_write = 1'b0;
  logic        en_after_ack = 1'b0;
  logic        ack_prev = 1'b0;
  int          cnt = 0;

  initial begin
    ack_auto  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_prev) en_after_ack = mem_enable_o;
      ack_prev = 1'b0;
      ack_auto = 1'b0;
      if (mem_enable_o && mem_write_o) seen_write = 1'b1;
      if (auto_on && mem_enable_o) begin
        cnt++;
        if (cnt >= lat) begin
          log_q.push_back('{mem_write_o, mem_addr_o, mem_data_o});
          if (!mem_write_o) mem_rdata = {8{fill_word}};
          ack_auto = 1'b1;
          ack_prev = 1'b1;
          cnt      = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Apply one request at a negedge, count stall cycles until it completes.
  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int stalls,
                         output logic [31:0] rdata, output logic timed_out);
    @(negedge clk);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    stalls    = 0;
    rdata     = '0;
    timed_out = 1'b1;
    for (int c = 0; c < 300; c++) begin
      #2;
      if (!cpu_stall_o) begin
        rdata     = cpu_data_o;
        timed_out = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] fill;
    int          exp_stall;
    logic [31:0] exp_data;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vt[10];

  int          stalls;
  logic [31:0] rdata;
  logic        tmo;
  int          nr;
  int          nw;
  tag_entry_t  te;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          10, 32'hAAAA_AAAA, 12, 32'hAAAA_AAAA, 1, 0};
    vt[1] = '{1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678,  10, 32'h0,          0, 32'h0,          0, 0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          10, 32'h0,          0, 32'h1234_5678, 0, 0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          10, 32'h0,          0, 32'hAAAA_AAAA, 0, 0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0504, 32'h0,          10, 32'h5555_5555, 22, 32'h5555_5555, 1, 1};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0900, 32'h0,           1, 32'h0900_0900,  3, 32'h0900_0900, 1, 0};
    vt[6] = '{1'b0, 1'b1, 32'h0000_0C08, 32'hDEAD_BEEF,   2, 32'h0BAD_F00D,  4, 32'h0,          1, 0};
    vt[7] = '{1'b1, 1'b0, 32'h0000_0C08, 32'h0,           2, 32'h0,          0, 32'hDEAD_BEEF, 0, 0};
    vt[8] = '{1'b1, 1'b0, 32'h0000_0C0C, 32'h0,           2, 32'h0,          0, 32'h0BAD_F00D, 0, 0};
    vt[9] = '{1'b1, 1'b0, 32'h0000_1C00, 32'h0,           2, 32'h7777_7777,  6, 32'h7777_7777, 1, 1};

    ack_man   = 1'b0;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0000_0100;
    cpu_wdata = 32'h0;
    rst_i     = 1'b0;

    // Reset with a request pending: all outputs must stay zero.
    repeat (3) @(negedge clk);
    #2;
    check32("rst stall",  {31'b0, cpu_stall_o},  32'd0);
    check32("rst enable", {31'b0, mem_enable_o}, 32'd0);
    check32("rst write",  {31'b0, mem_write_o},  32'd0);
    check32("rst addr",   mem_addr_o,            32'd0);
    check32("rst data",   mem_data_o[31:0] | mem_data_o[255:224], 32'd0);
    check32("rst cpu_data", cpu_data_o,          32'd0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check32("idle stall",  {31'b0, cpu_stall_o},  32'd0);
    check32("idle enable", {31'b0, mem_enable_o}, 32'd0);
    check32("idle state",  32'(dut.state),        32'(ST_IDLE));

    // Table-driven request sequence.
    for (int i = 0; i < 10; i++) begin
      lat        = vt[i].lat;
      fill_word  = vt[i].fill;
      log_q.delete();
      seen_write = 1'b0;
      en_after_ack = 1'b1;
      run_req(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, stalls, rdata, tmo);
      check32($sformatf("v%0d timeout", i), {31'b0, tmo}, 32'd0);
      check32($sformatf("v%0d stall cycles", i), stalls, vt[i].exp_stall);
      if (vt[i].rd) check32($sformatf("v%0d load data", i), rdata, vt[i].exp_data);
      nr = 0;
      nw = 0;
      foreach (log_q[k]) begin
        if (log_q[k].wr) nw++;
        else nr++;
      end
      check32($sformatf("v%0d refill reads", i), nr, vt[i].exp_rd);
      check32($sformatf("v%0d write-backs", i), nw, vt[i].exp_wr);
      if (i == 0 && log_q.size() >= 1)
        check32("v0 refill addr", log_q[0].addr, 32'h0000_0100);
      if (i == 1) begin
        te = dut.dcache_sram.tag_memory[8];
        check32("set8 dirty", {31'b0, te.dirty}, 32'd1);
      end
      if (i == 4 && log_q.size() >= 2) begin
        check32("v4 wb first",  {31'b0, log_q[0].wr}, 32'd1);
        check32("v4 wb addr",   log_q[0].addr,        32'h0000_0100);
        check32("v4 wb word1",  log_q[0].data[63:32], 32'h1234_5678);
        check32("v4 wb word0",  log_q[0].data[31:0],  32'hAAAA_AAAA);
        check32("v4 rd second", {31'b0, log_q[1].wr}, 32'd0);
        check32("v4 rd addr",   log_q[1].addr,        32'h0000_0500);
      end
      if (i == 5) begin
        check32("v5 write seen", {31'b0, seen_write}, 32'd0);
        check32("v5 enable after ack", {31'b0, en_after_ack}, 32'd0);
        if (log_q.size() >= 1) check32("v5 refill addr", log_q[0].addr, 32'h0000_0900);
      end
      if (i == 9 && log_q.size() >= 2) begin
        check32("v9 wb addr",  log_q[0].addr,        32'h0000_0C00);
        check32("v9 wb word2", log_q[0].data[95:64], 32'hDEAD_BEEF);
        check32("v9 wb word3", log_q[0].data[127:96], 32'h0BAD_F00D);
        check32("v9 rd addr",  log_q[1].addr,        32'h0000_1C00);
      end
    end

    // Reset in the middle of ALLOCATE, then a stray ack.
    auto_on = 1'b0;
    @(negedge clk);
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0100;
    repeat (5) @(negedge clk);
    #2;
    check32("mid alloc enable", {31'b0, mem_enable_o}, 32'd1);
    check32("mid alloc addr",   mem_addr_o,            32'h0000_0100);
    rst_i = 1'b0;
    #1;
    check32("mid rst stall",  {31'b0, cpu_stall_o},  32'd0);
    check32("mid rst enable", {31'b0, mem_enable_o}, 32'd0);
    check32("mid rst addr",   mem_addr_o,            32'd0);
    @(posedge clk);
    #1;
    rst_i    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    #2;
    check32("stray ack state",  32'(dut.state),        32'(ST_IDLE));
    check32("stray ack enable", {31'b0, mem_enable_o}, 32'd0);
    check32("stray ack stall",  {31'b0, cpu_stall_o},  32'd0);
    te = dut.dcache_sram.tag_memory[8];
    check32("set8 invalid", {31'b0, te.valid}, 32'd0);

    auto_on   = 1'b1;
    lat       = 10;
    fill_word = 32'hAAAA_AAAA;
    log_q.delete();
    run_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, stalls, rdata, tmo);
    check32("reload timeout", {31'b0, tmo}, 32'd0);
    check32("reload stall",   stalls, 12);
    check32("reload data",    rdata,  32'hAAAA_AAAA);
    check32("reload txns",    log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check32("reload is read", {31'b0, log_q[0].wr}, 32'd0);
      check32("reload addr",    log_q[0].addr,        32'h0000_0100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
